// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - writeback request bus between the writeback sources and the write arbiter
interface regfile_write_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int n      = 64,
   parameter int ADDR_W = 5
);
   logic [N_REQ-1:0]        req;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*n-1:0]      req_data;
   logic [N_REQ-1:0]        gnt;

   modport master (
      output req,
      output req_addr,
      output req_data,
      input  gnt
   );

   modport slave (
      input  req,
      input  req_addr,
      input  req_data,
      output gnt
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter for the single register bank write port
module regfile_write_arbiter #(
   parameter int N_REQ  = 4,
   parameter int n      = 64,
   parameter int ADDR_W = 5,
   localparam int PTR_W = $clog2(N_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   regfile_write_arbiter_if.slave bus,
   output logic                 regWrite,
   output logic [ADDR_W-1:0]    write_register,
   output logic [n-1:0]         write_data,
   output logic [PTR_W-1:0]     rr_ptr,
   output logic [15:0]          dropped_cnt
);

   logic [N_REQ-1:0]  gnt_c;
   logic              found;
   logic [PTR_W-1:0]  win;
   logic [PTR_W-1:0]  next_ptr;
   logic [ADDR_W-1:0] sel_addr;
   logic [n-1:0]      sel_data;
   int                idx;

   // Search starts at rr_ptr and wraps by explicit compare so non-power-of-two N_REQ works.
   always_comb begin
      gnt_c = '0;
      found = 1'b0;
      win   = '0;
      idx   = 0;
      if (!rst && !stall) begin
         for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) begin
               idx = idx - N_REQ;
            end
            if (!found && bus.req[idx]) begin
               found = 1'b1;
               win   = PTR_W'(idx);
            end
         end
      end
      if (found) begin
         gnt_c[win] = 1'b1;
      end
   end

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_c[i]) begin
            sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
            sel_data = bus.req_data[i*n +: n];
         end
      end
   end

   always_comb begin
      next_ptr = '0;
      if (win != PTR_W'(N_REQ - 1)) begin
         next_ptr = win + PTR_W'(1);
      end
   end

   assign bus.gnt = gnt_c;

   // Register-0 grants still advance the pointer and update the address/data latch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regWrite       <= 1'b0;
         write_register <= '0;
         write_data     <= '0;
         rr_ptr         <= '0;
         dropped_cnt    <= '0;
      end else if (found) begin
         write_register <= sel_addr;
         write_data     <= sel_data;
         regWrite       <= (sel_addr != '0);
         rr_ptr         <= next_ptr;
         if (sel_addr == '0 && dropped_cnt != 16'hFFFF) begin
            dropped_cnt <= dropped_cnt + 16'd1;
         end
      end else begin
         regWrite <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed table-driven bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

   typedef struct packed {
      logic            stall;
      logic [3:0]      req;
      logic [3:0][4:0] a;
      logic [3:0][63:0] d;
      logic [3:0]      g;
      logic            rw;
      logic [4:0]      wr;
      logic [63:0]     wd;
      logic [1:0]      p;
      logic [15:0]     dc;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall;
   logic        regWrite;
   logic [4:0]  write_register;
   logic [63:0] write_data;
   logic [1:0]  rr_ptr;
   logic [15:0] dropped_cnt;

   int total = 0;
   int bad   = 0;
   int gcount [4];

   vec_t vecs [0:19];

   regfile_write_arbiter_if #(.N_REQ(4), .n(64), .ADDR_W(5)) bus ();

   regfile_write_arbiter #(.N_REQ(4), .n(64), .ADDR_W(5)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .bus            (bus),
      .regWrite       (regWrite),
      .write_register (write_register),
      .write_data     (write_data),
      .rr_ptr         (rr_ptr),
      .dropped_cnt    (dropped_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic st, input logic [3:0] rq,
                               input logic [3:0][4:0] a, input logic [3:0][63:0] d,
                               input logic [3:0] g, input logic rw, input logic [4:0] wr,
                               input logic [63:0] wd, input logic [1:0] p, input logic [15:0] dc);
      vec_t v;
      v.stall = st; v.req = rq; v.a = a; v.d = d; v.g = g;
      v.rw = rw; v.wr = wr; v.wd = wd; v.p = p; v.dc = dc;
      return v;
   endfunction

   task automatic drive(input logic st, input logic [3:0] rq,
                        input logic [3:0][4:0] a, input logic [3:0][63:0] d);
      stall        = st;
      bus.req      = rq;
      bus.req_addr = a;
      bus.req_data = d;
   endtask

   initial begin
      logic [3:0][4:0]  a_rr;
      logic [3:0][63:0] d_rr;
      logic [3:0][4:0]  a_z;
      logic [3:0][63:0] d_z;
      logic [3:0][4:0]  a_s;
      logic [3:0][63:0] d_s;
      logic [3:0][4:0]  a_sa;
      logic [3:0][63:0] d_sa;
      logic [3:0][4:0]  a_w;
      logic [3:0][63:0] d_w;

      a_rr = {5'd4, 5'd3, 5'd2, 5'd1};
      d_rr = {64'h103, 64'h102, 64'h101, 64'h100};
      a_z  = '0;
      d_z  = '0;
      a_s  = {5'd0, 5'd0, 5'd4, 5'd3};
      d_s  = {64'h0, 64'h0, 64'h40, 64'h30};
      a_sa = {5'd0, 5'd5, 5'd5, 5'd0};
      d_sa = {64'h0, 64'hB, 64'hA, 64'h0};
      a_w  = {5'd31, 5'd0, 5'd0, 5'd0};
      d_w  = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 64'h0};

      for (int i = 0; i < 8; i++) begin
         vecs[i] = mk(1'b0, 4'b1111, a_rr, d_rr, 4'(1 << (i % 4)), 1'b1,
                      5'((i % 4) + 1), 64'h100 + 64'(i % 4), 2'((i + 1) % 4), 16'd0);
      end
      vecs[8]  = mk(1'b0, 4'b0100, {5'd0, 5'd7, 5'd0, 5'd0}, {64'h0, 64'hDEAD_BEEF, 64'h0, 64'h0},
                    4'b0100, 1'b1, 5'd7, 64'hDEAD_BEEF, 2'd3, 16'd0);
      vecs[9]  = mk(1'b0, 4'b0000, a_z, d_z, 4'b0000, 1'b0, 5'd7, 64'hDEAD_BEEF, 2'd3, 16'd0);
      vecs[10] = mk(1'b0, 4'b0001, a_z, {64'h0, 64'h0, 64'h0, 64'h1},
                    4'b0001, 1'b0, 5'd0, 64'h1, 2'd1, 16'd1);
      vecs[11] = mk(1'b1, 4'b0011, a_s, d_s, 4'b0000, 1'b0, 5'd0, 64'h1, 2'd1, 16'd1);
      vecs[12] = mk(1'b1, 4'b0011, a_s, d_s, 4'b0000, 1'b0, 5'd0, 64'h1, 2'd1, 16'd1);
      vecs[13] = mk(1'b1, 4'b0011, a_s, d_s, 4'b0000, 1'b0, 5'd0, 64'h1, 2'd1, 16'd1);
      vecs[14] = mk(1'b0, 4'b0011, a_s, d_s, 4'b0010, 1'b1, 5'd4, 64'h40, 2'd2, 16'd1);
      vecs[15] = mk(1'b0, 4'b0001, a_s, d_s, 4'b0001, 1'b1, 5'd3, 64'h30, 2'd1, 16'd1);
      vecs[16] = mk(1'b1, 4'b1000, a_w, d_w, 4'b0000, 1'b0, 5'd3, 64'h30, 2'd1, 16'd1);
      vecs[17] = mk(1'b0, 4'b0110, a_sa, d_sa, 4'b0010, 1'b1, 5'd5, 64'hA, 2'd2, 16'd1);
      vecs[18] = mk(1'b0, 4'b0100, a_sa, d_sa, 4'b0100, 1'b1, 5'd5, 64'hB, 2'd3, 16'd1);
      vecs[19] = mk(1'b0, 4'b1000, a_w, d_w, 4'b1000, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 16'd1);

      for (int k = 0; k < 4; k++) gcount[k] = 0;

      drive(1'b0, 4'b0000, a_z, d_z);
      #1 rst = 1'b1;
      #1;
      check("rst_regWrite", 64'(regWrite), 64'd0);
      check("rst_write_register", 64'(write_register), 64'd0);
      check("rst_write_data", write_data, 64'd0);
      check("rst_rr_ptr", 64'(rr_ptr), 64'd0);
      check("rst_dropped_cnt", 64'(dropped_cnt), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 20; i++) begin
         drive(vecs[i].stall, vecs[i].req, vecs[i].a, vecs[i].d);
         #2;
         check($sformatf("v%0d_gnt", i), 64'(bus.gnt), 64'(vecs[i].g));
         if (i < 8) begin
            for (int k = 0; k < 4; k++) if (bus.gnt[k]) gcount[k]++;
         end
         @(posedge clk);
         #1;
         check($sformatf("v%0d_regWrite", i), 64'(regWrite), 64'(vecs[i].rw));
         check($sformatf("v%0d_write_register", i), 64'(write_register), 64'(vecs[i].wr));
         check($sformatf("v%0d_write_data", i), write_data, vecs[i].wd);
         check($sformatf("v%0d_rr_ptr", i), 64'(rr_ptr), 64'(vecs[i].p));
         check($sformatf("v%0d_dropped_cnt", i), 64'(dropped_cnt), 64'(vecs[i].dc));
      end

      for (int k = 0; k < 4; k++) begin
         check($sformatf("rr_grants_req%0d", k), 64'(gcount[k]), 64'd2);
      end

      // Async reset while a registered write is pending.
      drive(1'b0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd9}, {64'h0, 64'h0, 64'h0, 64'h99});
      @(posedge clk);
      #1;
      check("mid_pre_regWrite", 64'(regWrite), 64'd1);
      check("mid_pre_write_register", 64'(write_register), 64'd9);
      bus.req = 4'b0000;
      #2 rst = 1'b1;
      #1;
      check("mid_regWrite", 64'(regWrite), 64'd0);
      check("mid_rr_ptr", 64'(rr_ptr), 64'd0);
      check("mid_dropped_cnt", 64'(dropped_cnt), 64'd0);
      check("mid_write_register", 64'(write_register), 64'd0);
      check("mid_write_data", write_data, 64'd0);
      bus.req = 4'b0001;
      #1;
      check("mid_gnt_in_rst", 64'(bus.gnt), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_rst_gnt", 64'(bus.gnt), 64'b0001);

      // Saturation of the register-0 drop counter.
      drive(1'b0, 4'b0001, a_z, d_z);
      repeat (65535) @(posedge clk);
      #1;
      check("sat_dropped_cnt", 64'(dropped_cnt), 64'hFFFF);
      check("sat_regWrite", 64'(regWrite), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check("sat_hold_dropped_cnt", 64'(dropped_cnt), 64'hFFFF);
      bus.req = 4'b0000;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32 x 64-bit register bank between N_REQ writeback sources (ALU, load unit, multiplier, ...).
- Round-robin arbitration with a per-requester req/gnt handshake.
- Drives the bank's regWrite / write_register / write_data through a one-stage registered output.
- Sits between the execute/writeback units and the register bank. Provides stall and register-0 write suppression.

Parameters:
- N_REQ, 4, number of write requesters (2..8).
- n, 64, data width; matches the register bank word.
- ADDR_W, 5, register address width (32 registers).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  when high, no grant is issued this cycle.
- req  input  N_REQ  per-requester write request; bit i belongs to requester i.
- req_addr  input  N_REQ*ADDR_W  flattened destination addresses; slice i is [i*ADDR_W +: ADDR_W].
- req_data  input  N_REQ*n  flattened write data; slice i is [i*n +: n].
- gnt  output  N_REQ  one-hot (or zero) combinational grant; a transfer completes when req[i] & gnt[i].
- regWrite  output  1  registered write enable to the register bank.
- write_register  output  ADDR_W  registered write address.
- write_data  output  n  registered write data.
- rr_ptr  output  clog2(N_REQ)  current highest-priority requester index (debug/verification).
- dropped_cnt  output  16  saturating count of suppressed writes to register 0.

Behaviour:
- Reset (async, rst=1):
  - regWrite=0, write_register=0, write_data=0.
  - rr_ptr=0, dropped_cnt=0.
  - gnt=0 while rst is high.
- Arbitration (combinational, cycle T):
  - If stall=1 or req=0: gnt=0.
  - Otherwise gnt selects the first i with req[i]=1, searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - Exactly one gnt bit is high when any req is high and stall=0.
- Handshake:
  - A requester holds req, req_addr and req_data stable until it sees gnt.
  - It may deassert req in the cycle after the grant.
  - Non-granted requesters keep waiting; requests are never lost.
- Winner w at T, registered at posedge ending T:
  - write_register <= req_addr[w].
  - write_data <= req_data[w].
  - regWrite <= 1 if req_addr[w] != 0.
  - Latency: grant cycle T to bank write at the posedge ending T+1 (one register stage).
- Pointer:
  - rr_ptr <= (w+1) mod N_REQ on every grant, including suppressed register-0 writes.
  - rr_ptr is unchanged when there is no grant.
- Register 0:
  - A grant to address 0 is acknowledged (gnt high), regWrite stays 0.
  - dropped_cnt increments, saturating at 16'hFFFF.
- No grant in cycle T:
  - regWrite <= 0.
  - write_register and write_data hold their previous values.
- Simultaneous requests:
  - Only one winner per cycle.
  - With all N_REQ requesting continuously, each is granted exactly once every N_REQ cycles (starvation-free).
- Same-address requests:
  - Two requesters targeting the same register are serviced in grant order; the later write wins in the bank.
  - No merging of writes.
- Stall:
  - stall=1 forces gnt=0 and regWrite <= 0 next cycle.
  - rr_ptr is held.
  - A write already registered (regWrite=1) still completes during the stall cycle.
- Reset mid-operation:
  - Asserting rst clears the output stage immediately, so a pending registered write is discarded.
  - Requesters re-present their requests after reset.
- Widths:
  - rr_ptr wraps from N_REQ-1 to 0.
  - N_REQ not a power of two is supported via explicit modulo compare, not bit truncation.

Test Plan:
- Single request: reset, then req=4'b0100, req_addr slice2=5'd7, req_data slice2=64'hDEAD_BEEF held 1 cycle -> gnt=4'b0100 in same cycle; next cycle regWrite=1, write_register=7, write_data=64'hDEAD_BEEF; rr_ptr=3.
- Round-robin fairness: req=4'b1111 for 8 cycles, rr_ptr=0 at start, addresses 1..4 -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000; every requester granted twice.
- Register-0 suppression: req=4'b0001, addr=0, data=64'h1 -> gnt=4'b0001; next cycle regWrite=0; dropped_cnt=1; rr_ptr=1.
- Stall: req=4'b0011 with stall=1 for 3 cycles, then stall=0 -> gnt=0 and regWrite=0 during the stall, rr_ptr held; first grant after the stall goes to rr_ptr's requester.
- Async reset mid-write: a grant occurs, rst pulses high between clock edges before the output registers are used -> regWrite drops to 0 immediately; rr_ptr=0, dropped_cnt=0.
- Same-address ordering: requesters 1 and 2 both write register 5 with data 64'hA and 64'hB, rr_ptr=1 -> bank sees 64'hA, then 64'hB on consecutive cycles.
